// File: rtl/bm_disp_fb_read_master_pkg.sv
// Shared constants and types for the bitmap display frame-buffer read master.
// AXI encodings here are also used by the register slave.
package bm_disp_fb_read_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_ARCACHE    = 4'b0011;
    localparam logic [2:0] AXI_ARPROT     = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRoom,
        StAddr,
        StData,
        StNext
    } fetch_state_e;

endpackage

// File: rtl/bm_disp_fb_read_master.sv
// AXI4 read master: fetches whole frames of 32-bit pixels in fixed INCR bursts
// and pushes them, tagged with a start-of-frame bit, into the external pixel FIFO.
module bm_disp_fb_read_master
    import bm_disp_fb_read_master_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_H_PIXELS         = 800,
    parameter int unsigned C_V_LINES          = 600,
    parameter int unsigned C_BURST_LEN        = 256
) (
    input  logic                            m_axi_aclk,
    input  logic                            axi_resetn,
    input  logic [31:0]                     fb_start_address,
    input  logic                            init_done,
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic [3:0]                      m_axi_arcache,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH:0]     fifo_din,
    output logic                            fifo_wr_en,
    input  logic                            fifo_almost_full,
    output logic                            rresp_err
);

    localparam int unsigned AW          = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned TotalBursts = C_H_PIXELS * C_V_LINES / C_BURST_LEN;
    localparam int unsigned CntW        = (TotalBursts > 1) ? $clog2(TotalBursts) : 1;
    localparam int unsigned AlignBits   = $clog2(C_BURST_LEN * 4);

    localparam logic [AW-1:0]   BurstBytes = AW'(C_BURST_LEN * 4);
    localparam logic [AW-1:0]   AlignMask  = ~AW'((64'd1 << AlignBits) - 64'd1);
    localparam logic [CntW-1:0] LastBurst  = CntW'(TotalBursts - 1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [AW-1:0]   r_burst_addr;
    logic [CntW-1:0] r_burst_cnt;
    logic            r_sof_pend;
    logic            r_frame_end;
    logic            r_rresp_err;
    logic [AW-1:0]   w_base;
    logic            w_beat;

    // Base is burst-aligned so a fixed-size burst can never cross a 4 KB page.
    assign w_base = AW'(fb_start_address) & AlignMask;

    always_ff @(posedge m_axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:     if (init_done)         w_state_nxt = StWaitRoom;
            StWaitRoom: if (!fifo_almost_full) w_state_nxt = StAddr;
            StAddr:     if (m_axi_arready)     w_state_nxt = StData;
            StData:     if (m_axi_rvalid && m_axi_rlast) w_state_nxt = StNext;
            StNext:                            w_state_nxt = StWaitRoom;
            default:                           w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        m_axi_arvalid = (r_state == StAddr);
        m_axi_rready  = (r_state == StData);
        w_beat        = m_axi_rvalid && (r_state == StData);
        fifo_wr_en    = w_beat;
        fifo_din      = {r_sof_pend, m_axi_rdata};
    end

    always_ff @(posedge m_axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_burst_addr <= '0;
            r_burst_cnt  <= '0;
            r_sof_pend   <= 1'b0;
            r_frame_end  <= 1'b0;
            r_rresp_err  <= 1'b0;
        end else begin
            if (w_beat && (m_axi_rresp != RESP_OKAY)) begin
                r_rresp_err <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (init_done) begin
                        r_burst_addr <= w_base;
                        r_burst_cnt  <= '0;
                        r_sof_pend   <= 1'b1;
                        r_frame_end  <= 1'b0;
                    end
                end
                StData: begin
                    if (w_beat) begin
                        r_sof_pend <= 1'b0;
                        if (m_axi_rlast) begin
                            r_burst_cnt  <= r_burst_cnt + 1'b1;
                            r_burst_addr <= r_burst_addr + BurstBytes;
                            r_frame_end  <= (r_burst_cnt == LastBurst);
                        end
                    end
                end
                StNext: begin
                    // Base address changes only here, so a frame is never split.
                    if (r_frame_end) begin
                        r_burst_addr <= w_base;
                        r_burst_cnt  <= '0;
                        r_sof_pend   <= 1'b1;
                        r_frame_end  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = r_burst_addr;
    assign m_axi_arlen   = 8'(C_BURST_LEN - 1);
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arcache = AXI_ARCACHE;
    assign m_axi_arprot  = AXI_ARPROT;
    assign rresp_err     = r_rresp_err;

endmodule

// File: tb/tb_bm_disp_fb_read_master.sv
// Directed bench for bm_disp_fb_read_master with a 16x4 frame and 16-beat bursts.
module tb_bm_disp_fb_read_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fb_start_address;
    logic        init_done;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [32:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_almost_full;
    logic        rresp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bm_disp_fb_read_master #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ID_WIDTH   (1),
        .C_H_PIXELS         (16),
        .C_V_LINES          (4),
        .C_BURST_LEN        (16)
    ) dut (
        .m_axi_aclk       (clk),
        .axi_resetn       (rst_n),
        .fb_start_address (fb_start_address),
        .init_done        (init_done),
        .m_axi_arid       (arid),
        .m_axi_araddr     (araddr),
        .m_axi_arlen      (arlen),
        .m_axi_arsize     (arsize),
        .m_axi_arburst    (arburst),
        .m_axi_arcache    (arcache),
        .m_axi_arprot     (arprot),
        .m_axi_arvalid    (arvalid),
        .m_axi_arready    (arready),
        .m_axi_rdata      (rdata),
        .m_axi_rresp      (rresp),
        .m_axi_rlast      (rlast),
        .m_axi_rvalid     (rvalid),
        .m_axi_rready     (rready),
        .fifo_din         (fifo_din),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_almost_full (fifo_almost_full),
        .rresp_err        (rresp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the AXI slave for one burst; enters and leaves 1 time unit after a clock edge.
    task automatic serve_burst(input logic [31:0] exp_addr, input bit first, input int err_beat,
                               input int abort_beat, input bit stall);
        int          wait_cyc;
        logic [32:0] exp_din;
        wait_cyc = 0;
        while (!arvalid && wait_cyc < 200) begin
            tick();
            wait_cyc++;
        end
        checks++;
        if (arvalid !== 1'b1) begin
            errors++;
            $display("FAIL ar_timeout: arvalid=%b want 1 (addr %h)", arvalid, exp_addr);
            return;
        end
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                checks++;
                if (araddr !== exp_addr || arvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL ar_stable: araddr=%h arvalid=%b want %h 1",
                             araddr, arvalid, exp_addr);
                end
                tick();
            end
        end
        checks++;
        if (araddr !== exp_addr) begin
            errors++;
            $display("FAIL araddr: got %h want %h", araddr, exp_addr);
        end
        checks++;
        if (arlen !== 8'd15) begin
            errors++;
            $display("FAIL arlen: got %0d want 15", arlen);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake: arvalid=%b rready=%b want 0 1", arvalid, rready);
        end
        for (int b = 0; b < 16; b++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    rvalid = 1'b0;
                    #1;
                    checks++;
                    if (fifo_wr_en !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_wr: fifo_wr_en=%b want 0", fifo_wr_en);
                    end
                    @(posedge clk);
                    #1;
                end
            end
            rvalid = 1'b1;
            rdata  = 32'hC0DE_0000 | 32'(b);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == 15);
            exp_din = {(first && b == 0), 32'hC0DE_0000 | 32'(b)};
            #1;
            checks++;
            if (fifo_wr_en !== 1'b1 || fifo_din !== exp_din) begin
                errors++;
                $display("FAIL beat%0d: wr_en=%b din=%h want 1 %h", b, fifo_wr_en, fifo_din,
                         exp_din);
            end
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({arvalid, rready, fifo_wr_en, rresp_err} !== 4'b0000) begin
                    errors++;
                    $display("FAIL async_reset: arvalid/rready/wr_en/err=%b want 0000",
                             {arvalid, rready, fifo_wr_en, rresp_err});
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                return;
            end
            @(posedge clk);
            #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        checks++;
        if (rready !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL after_rlast: rready=%b wr_en=%b want 0 0", rready, fifo_wr_en);
        end
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({arvalid, rready, fifo_wr_en, rresp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {arvalid, rready, fifo_wr_en, rresp_err});
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            tick();
            if (arvalid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_init_done: arvalid high %0d cycles want 0", seen);
        end
        checks++;
        if ({arid, arsize, arburst, arcache, arprot} !== {1'b0, 3'b010, 2'b01, 4'b0011, 3'b000})
        begin
            errors++;
            $display("FAIL static_ar: id=%h size=%h burst=%h cache=%h prot=%h want 0 2 1 3 0",
                     arid, arsize, arburst, arcache, arprot);
        end
    endtask

    task automatic test_first_frame();
        fb_start_address = 32'h1A00_0000;
        init_done = 1'b1;
        for (int i = 0; i < 4; i++) serve_burst(32'h1A00_0000 + 32'(i * 64), i == 0, -1, -1, 0);
        checks++;
        if (rresp_err !== 1'b0) begin
            errors++;
            $display("FAIL rresp_err_clean: got %b want 0", rresp_err);
        end
    endtask

    task automatic test_back_to_back();
        serve_burst(32'h1A00_0000, 1, -1, -1, 0);
        serve_burst(32'h1A00_0040, 0, -1, -1, 0);
    endtask

    task automatic test_address_change();
        // Unaligned on purpose: low 6 bits must be dropped.
        fb_start_address = 32'h1B00_0025;
        serve_burst(32'h1A00_0080, 0, -1, -1, 0);
        serve_burst(32'h1A00_00C0, 0, -1, -1, 0);
        serve_burst(32'h1B00_0000, 1, -1, -1, 0);
    endtask

    task automatic test_backpressure();
        int seen;
        fifo_almost_full = 1'b1;
        seen = 0;
        repeat (50) begin
            tick();
            if (arvalid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL almost_full_hold: arvalid high %0d cycles want 0", seen);
        end
        fifo_almost_full = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_latency_early: arvalid=%b want 0", arvalid);
        end
        tick();
        checks++;
        if (arvalid !== 1'b1) begin
            errors++;
            $display("FAIL ar_latency: arvalid=%b want 1", arvalid);
        end
        for (int i = 1; i < 4; i++) serve_burst(32'h1B00_0000 + 32'(i * 64), 0, -1, -1, 1);
    endtask

    task automatic test_rresp_err();
        serve_burst(32'h1B00_0000, 1, 5, -1, 0);
        checks++;
        if (rresp_err !== 1'b1) begin
            errors++;
            $display("FAIL rresp_err_set: got %b want 1", rresp_err);
        end
        serve_burst(32'h1B00_0040, 0, -1, -1, 0);
        checks++;
        if (rresp_err !== 1'b1) begin
            errors++;
            $display("FAIL rresp_err_sticky: got %b want 1", rresp_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        serve_burst(32'h1B00_0080, 0, -1, 7, 0);
        repeat (3) tick();
        checks++;
        if ({arvalid, rready, fifo_wr_en, rresp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got %b want 0000", {arvalid, rready, fifo_wr_en, rresp_err});
        end
        rst_n = 1'b1;
        serve_burst(32'h1B00_0000, 1, -1, -1, 0);
        checks++;
        if (rresp_err !== 1'b0) begin
            errors++;
            $display("FAIL rresp_err_after_reset: got %b want 0", rresp_err);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        fb_start_address = 32'h0;
        init_done        = 1'b0;
        arready          = 1'b0;
        rdata            = 32'h0;
        rresp            = 2'b00;
        rlast            = 1'b0;
        rvalid           = 1'b0;
        fifo_almost_full = 1'b0;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_address_change();
        test_backpressure();
        test_rresp_err();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
